// File: rtl/pic_pkg.sv
// Shared types and register bit positions for the 8259-style PIC control sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    StUninit,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } init_st_e;

  typedef enum logic [1:0] {
    StAIdle,
    StAck1,
    StAck2
  } inta_st_e;

  localparam int unsigned Icw1Ic4  = 0;
  localparam int unsigned Icw1Sngl = 1;
  localparam int unsigned Icw1Ltim = 3;
  localparam int unsigned Icw1Sel  = 4;
  localparam int unsigned Icw4Aeoi = 1;
  localparam int unsigned Ocw2Eoi  = 5;
  localparam int unsigned Ocw2Sl   = 6;
  localparam int unsigned Ocw2Rot  = 7;
  localparam int unsigned Ocw3Sel  = 3;
  localparam int unsigned Ocw3Rr   = 1;
  localparam int unsigned Ocw3Ris  = 0;

  localparam logic RdSelIrr = 1'b0;
  localparam logic RdSelIsr = 1'b1;

  // Index of the least significant set bit; 0 when none is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_control_sequencer_strobe_sync.sv
// Synchronizes an asynchronous active-low strobe pin and flags each change of the
// synchronized level with a one-cycle pulse.
module pic_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic chg
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Idle level is high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl = sync_q[SYNC_STAGES-1];
  assign chg = lvl ^ prev_q;

endmodule

// File: rtl/pic_control_sequencer.sv
// Control core of the 8259-style PIC: ICW/OCW decode, init FSM, two-pulse INTA
// handshake, INT generation, and ISR-set / EOI pulses to the priority block.
module pic_control_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SPURIOUS_LVL = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic [7:0] irr_in,
  input  logic [7:0] isr_in,
  input  logic       pend,
  input  logic [2:0] pri_lvl,
  output logic       intr,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic [7:0] imr,
  output logic       ltim,
  output logic       aeoi,
  output logic       rotate,
  output logic       isr_set,
  output logic [2:0] isr_lvl,
  output logic       eoi,
  output logic [2:0] eoi_lvl,
  output logic       init_clr
);

  logic wr_lvl, wr_chg, rd_lvl, rd_chg, inta_lvl, inta_chg;

  pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst_n(rst_n), .pin(wr_n), .lvl(wr_lvl), .chg(wr_chg)
  );
  pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst_n(rst_n), .pin(rd_n), .lvl(rd_lvl), .chg(rd_chg)
  );
  pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inta_sync (
    .clk(clk), .rst_n(rst_n), .pin(inta_n), .lvl(inta_lvl), .chg(inta_chg)
  );

  init_st_e   init_q, init_d;
  inta_st_e   inta_q, inta_d;
  logic [7:0] imr_q, imr_d;
  logic [4:0] vec_q, vec_d;
  logic [2:0] lvl_q, lvl_d, isr_lvl_q, isr_lvl_d, eoi_lvl_q, eoi_lvl_d, epend_lvl_q, epend_lvl_d;
  logic       ltim_q, ltim_d, aeoi_q, aeoi_d, rot_q, rot_d, ic4_q, ic4_d, sngl_q, sngl_d;
  logic       sel_q, sel_d, set_done_q, set_done_d, intr_q, intr_d, rd_act_q, rd_act_d;
  logic       isr_set_q, isr_set_d, eoi_q, eoi_d, epend_q, epend_d, init_clr_q, init_clr_d;
  logic       wr_ev, icw1, ocw_eoi, aeoi_eoi;
  logic [2:0] ocw_eoi_lvl;

  assign wr_ev = wr_chg & ~wr_lvl & ~cs_n;
  assign icw1  = wr_ev & ~a0 & din[Icw1Sel];

  always_comb begin
    init_d = init_q;  inta_d = inta_q;  imr_d = imr_q;  vec_d = vec_q;  lvl_d = lvl_q;
    ltim_d = ltim_q;  aeoi_d = aeoi_q;  rot_d = rot_q;  ic4_d = ic4_q;  sngl_d = sngl_q;
    sel_d = sel_q;  set_done_d = set_done_q;  rd_act_d = rd_act_q;
    isr_set_d = 1'b0;  isr_lvl_d = isr_lvl_q;  eoi_d = 1'b0;  eoi_lvl_d = eoi_lvl_q;
    epend_d = epend_q;  epend_lvl_d = epend_lvl_q;  init_clr_d = 1'b0;
    ocw_eoi = 1'b0;  ocw_eoi_lvl = 3'd0;  aeoi_eoi = 1'b0;

    if (rd_chg && !rd_lvl && !cs_n) rd_act_d = 1'b1;
    if (rd_chg && rd_lvl)           rd_act_d = 1'b0;

    if (icw1) begin
      init_d = StWaitIcw2;  inta_d = StAIdle;
      ltim_d = din[Icw1Ltim];  ic4_d = din[Icw1Ic4];  sngl_d = din[Icw1Sngl];
      imr_d = 8'h00;  aeoi_d = 1'b0;  rot_d = 1'b0;  sel_d = RdSelIrr;  init_clr_d = 1'b1;
    end else if (wr_ev) begin
      unique case (init_q)
        StWaitIcw2: if (a0) begin
          vec_d  = din[7:3];
          init_d = !sngl_q ? StWaitIcw3 : (ic4_q ? StWaitIcw4 : StReady);
        end
        StWaitIcw3: if (a0) init_d = ic4_q ? StWaitIcw4 : StReady;
        StWaitIcw4: if (a0) begin
          aeoi_d = din[Icw4Aeoi];
          init_d = StReady;
        end
        StReady: begin
          if (a0) begin
            imr_d = din;
          end else if (!din[Ocw3Sel]) begin
            rot_d = din[Ocw2Rot];
            if (din[Ocw2Eoi]) begin
              ocw_eoi     = din[Ocw2Sl] | (isr_in != 8'h00);
              ocw_eoi_lvl = din[Ocw2Sl] ? din[2:0] : lowest_set(isr_in);
            end
          end else if (din[Ocw3Rr]) begin
            sel_d = din[Ocw3Ris];
          end
        end
        default: ;
      endcase
    end

    // ICW1 in the same cycle takes precedence and has already forced StAIdle.
    if (!icw1 && init_q == StReady && inta_chg) begin
      unique case (inta_q)
        StAIdle: if (!inta_lvl) begin
          inta_d     = StAck1;
          lvl_d      = pend ? pri_lvl : 3'(SPURIOUS_LVL);
          set_done_d = pend;
          isr_set_d  = pend;
          isr_lvl_d  = pend ? pri_lvl : isr_lvl_q;
        end
        StAck1: if (!inta_lvl) inta_d = StAck2;
        StAck2: if (inta_lvl) begin
          inta_d   = StAIdle;
          aeoi_eoi = aeoi_q & set_done_q;
        end
        default: ;
      endcase
    end

    // OCW2 EOI wins the pulse slot; an auto-EOI that loses is parked for a later cycle.
    if (ocw_eoi) begin
      eoi_d = 1'b1;  eoi_lvl_d = ocw_eoi_lvl;
      if (aeoi_eoi) begin
        epend_d = 1'b1;  epend_lvl_d = lvl_q;
      end
    end else if (epend_q) begin
      eoi_d = 1'b1;  eoi_lvl_d = epend_lvl_q;
      epend_d = aeoi_eoi;  epend_lvl_d = lvl_q;
    end else if (aeoi_eoi) begin
      eoi_d = 1'b1;  eoi_lvl_d = lvl_q;
    end

    intr_d = (init_d == StReady) && pend && (inta_d == StAIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= StUninit;  inta_q <= StAIdle;  imr_q <= 8'h00;  vec_q <= 5'd0;  lvl_q <= 3'd0;
      ltim_q <= 1'b0;  aeoi_q <= 1'b0;  rot_q <= 1'b0;  ic4_q <= 1'b0;  sngl_q <= 1'b0;
      sel_q <= RdSelIrr;  set_done_q <= 1'b0;  intr_q <= 1'b0;  rd_act_q <= 1'b0;
      isr_set_q <= 1'b0;  isr_lvl_q <= 3'd0;  eoi_q <= 1'b0;  eoi_lvl_q <= 3'd0;
      epend_q <= 1'b0;  epend_lvl_q <= 3'd0;  init_clr_q <= 1'b0;
    end else begin
      init_q <= init_d;  inta_q <= inta_d;  imr_q <= imr_d;  vec_q <= vec_d;  lvl_q <= lvl_d;
      ltim_q <= ltim_d;  aeoi_q <= aeoi_d;  rot_q <= rot_d;  ic4_q <= ic4_d;  sngl_q <= sngl_d;
      sel_q <= sel_d;  set_done_q <= set_done_d;  intr_q <= intr_d;  rd_act_q <= rd_act_d;
      isr_set_q <= isr_set_d;  isr_lvl_q <= isr_lvl_d;  eoi_q <= eoi_d;  eoi_lvl_q <= eoi_lvl_d;
      epend_q <= epend_d;  epend_lvl_q <= epend_lvl_d;  init_clr_q <= init_clr_d;
    end
  end

  logic rd_drive, vec_drive;
  assign rd_drive  = rd_act_q & ~cs_n & (inta_q == StAIdle);
  assign vec_drive = (inta_q == StAck2) & ~inta_lvl;

  always_comb begin
    dout = 8'h00;
    if (vec_drive)     dout = {vec_q, lvl_q};
    else if (rd_drive) dout = a0 ? imr_q : ((sel_q == RdSelIsr) ? isr_in : irr_in);
  end

  assign dout_en  = rd_drive | vec_drive;
  assign intr     = intr_q;
  assign imr      = imr_q;
  assign ltim     = ltim_q;
  assign aeoi     = aeoi_q;
  assign rotate   = rot_q;
  assign isr_set  = isr_set_q;
  assign isr_lvl  = isr_lvl_q;
  assign eoi      = eoi_q;
  assign eoi_lvl  = eoi_lvl_q;
  assign init_clr = init_clr_q;

endmodule

// File: tb/tb_pic_control_sequencer.sv
// Directed bench for pic_control_sequencer: a vector table for the READY-state decode
// plus hand-written sequences for init, the INTA handshake, ICW1 abort and async reset.
module tb_pic_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0, inta_n = 1'b1;
  logic [7:0] din = 8'h00, irr_in = 8'h5A, isr_in = 8'h00;
  logic       pend = 1'b0;
  logic [2:0] pri_lvl = 3'd0;
  logic       intr, dout_en, ltim, aeoi, rotate, isr_set, eoi, init_clr;
  logic [7:0] dout, imr;
  logic [2:0] isr_lvl, eoi_lvl;

  pic_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .din(din),
    .inta_n(inta_n), .irr_in(irr_in), .isr_in(isr_in), .pend(pend), .pri_lvl(pri_lvl),
    .intr(intr), .dout(dout), .dout_en(dout_en), .imr(imr), .ltim(ltim), .aeoi(aeoi),
    .rotate(rotate), .isr_set(isr_set), .isr_lvl(isr_lvl), .eoi(eoi), .eoi_lvl(eoi_lvl),
    .init_clr(init_clr)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int isr_cnt = 0, eoi_cnt = 0, clr_cnt = 0;
  logic [2:0] isr_last = 3'd0, eoi_last = 3'd0;

  always @(negedge clk) begin
    if (isr_set)  begin isr_cnt++; isr_last = isr_lvl; end
    if (eoi)      begin eoi_cnt++; eoi_last = eoi_lvl; end
    if (init_clr) clr_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk); cs_n = 1'b0; a0 = a; din = d; wr_n = 1'b0;
    tick(5); @(negedge clk); wr_n = 1'b1;
    tick(5); @(negedge clk); cs_n = 1'b1;
  endtask

  task automatic rd(input logic a, output logic [7:0] d, output logic en);
    @(negedge clk); cs_n = 1'b0; a0 = a; rd_n = 1'b0;
    tick(5); @(negedge clk); d = dout; en = dout_en;
    rd_n = 1'b1;
    tick(5); @(negedge clk); cs_n = 1'b1;
  endtask

  task automatic inta(input logic lvl);
    @(negedge clk); inta_n = lvl;
    tick(5); @(negedge clk);
  endtask

  typedef struct {
    logic       a0;
    logic [7:0] din;
    logic [7:0] isr;
    logic [7:0] e_imr;
    logic       e_rot;
    logic       e_eoi;
    logic [2:0] e_lvl;
    logic       rd_a0;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] d;
    logic       en;
    int         e0, i0, c0;

    vecs[0] = '{1'b0, 8'h20, 8'h28, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 8'h65, 8'h28, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0, 8'h5A};
    vecs[2] = '{1'b0, 8'h80, 8'h28, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h5A};
    vecs[3] = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h5A};
    vecs[4] = '{1'b1, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b1, 8'hA5};
    vecs[5] = '{1'b0, 8'h0B, 8'h3C, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h3C};
    vecs[6] = '{1'b0, 8'h0A, 8'h3C, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h5A};
    vecs[7] = '{1'b0, 8'h09, 8'h3C, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h5A};
    vecs[8] = '{1'b0, 8'hE0, 8'h00, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b1, 8'hA5};

    // Reset state
    tick(3); @(negedge clk);
    chk("reset_outputs", {intr, dout_en, dout, imr, ltim, aeoi, rotate, isr_set, eoi, init_clr},
        0);
    rst_n = 1'b1;
    tick(2);

    // 1: init with AEOI
    wr(1'b0, 8'h13);
    chk("init_clr_once", clr_cnt, 1);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h03);
    chk("aeoi_set", aeoi, 1);
    chk("ltim_edge", ltim, 0);

    // 2: full INTA handshake with AEOI
    pend = 1'b1; pri_lvl = 3'd3;
    tick(3); @(negedge clk);
    chk("int_asserted", intr, 1);
    inta(1'b0);
    chk("isr_set_count", isr_cnt, 1);
    chk("isr_set_lvl", isr_last, 3);
    chk("int_cleared_ack1", intr, 0);
    inta(1'b1);
    e0 = eoi_cnt;
    inta(1'b0);
    chk("vector_en", dout_en, 1);
    chk("vector", dout, 8'h43);
    inta(1'b1);
    chk("aeoi_eoi_count", eoi_cnt - e0, 1);
    chk("aeoi_eoi_lvl", eoi_last, 3);
    chk("vector_released", dout_en, 0);
    pend = 1'b0;

    // 3/4: READY decode table with AEOI off
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h01);
    chk("aeoi_clear", aeoi, 0);
    foreach (vecs[k]) begin
      isr_in = vecs[k].isr;
      e0 = eoi_cnt;
      wr(vecs[k].a0, vecs[k].din);
      tick(2); @(negedge clk);
      chk($sformatf("v%0d_imr", k), imr, vecs[k].e_imr);
      chk($sformatf("v%0d_rotate", k), rotate, vecs[k].e_rot);
      chk($sformatf("v%0d_eoi_count", k), eoi_cnt - e0, vecs[k].e_eoi);
      if (vecs[k].e_eoi) chk($sformatf("v%0d_eoi_lvl", k), eoi_last, vecs[k].e_lvl);
      rd(vecs[k].rd_a0, d, en);
      chk($sformatf("v%0d_dout_en", k), en, 1);
      chk($sformatf("v%0d_dout", k), d, vecs[k].e_dout);
    end

    // 5: spurious acknowledge, then ICW1 between ACK1 and ACK2
    i0 = isr_cnt;
    inta(1'b0);
    chk("spurious_no_isr_set", isr_cnt - i0, 0);
    inta(1'b1);
    inta(1'b0);
    chk("spurious_vector", dout, 8'h47);
    inta(1'b1);
    inta(1'b0);
    inta(1'b1);
    c0 = clr_cnt;
    wr(1'b0, 8'h19);
    chk("restart_init_clr", clr_cnt - c0, 1);
    chk("restart_imr_clr", imr, 0);
    chk("restart_ltim", ltim, 1);
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h00);
    wr(1'b1, 8'h03);
    chk("cascade_path_aeoi", aeoi, 1);
    inta(1'b0);
    chk("abort_to_idle", dout_en, 0);
    inta(1'b1);
    inta(1'b0);
    chk("after_abort_vector", dout, 8'h47);
    inta(1'b1);

    // 6: reset during ACK2
    wr(1'b1, 8'h0F);
    pend = 1'b1; pri_lvl = 3'd2;
    tick(3); @(negedge clk);
    chk("int_before_reset", intr, 1);
    inta(1'b0);
    inta(1'b1);
    inta(1'b0);
    chk("ack2_vector", dout, 8'h42);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout_en", dout_en, 0);
    chk("rst_int", intr, 0);
    chk("rst_imr", imr, 0);
    chk("rst_aeoi", aeoi, 0);
    inta_n = 1'b1;
    tick(3); @(negedge clk);
    e0 = eoi_cnt;
    rst_n = 1'b1;
    tick(10); @(negedge clk);
    chk("no_eoi_after_reset", eoi_cnt - e0, 0);
    chk("int_uninit", intr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
